// File: rtl/time_display.sv
// Multiplexed four-digit MM.SS seven-segment driver for the stopwatch.
// Binary minutes/seconds are converted to BCD with a sequential double-dabble,
// then scanned one digit at a time with optional blink and blank control.
module time_display #(
    parameter int SCAN_DIV  = 32500,
    parameter int BLINK_DIV = 16250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blank,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t             state;
    logic [5:0]         cap_min;
    logic [5:0]         cap_sec;
    // Shift register layout: [13:10] tens, [9:6] ones, [5:0] binary remainder
    logic [13:0]        sh_min;
    logic [13:0]        sh_sec;
    logic [2:0]         cnt;
    logic [3:0]         dig [4];

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes go dark
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM: capture on change, six double-dabble shifts, load digits
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cap_min <= '0;
            cap_sec <= '0;
            sh_min  <= '0;
            sh_sec  <= '0;
            cnt     <= '0;
            for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ({minutes, seconds} != {cap_min, cap_sec}) begin
                        cap_min <= minutes;
                        cap_sec <= seconds;
                        sh_min  <= {8'd0, minutes};
                        sh_sec  <= {8'd0, seconds};
                        cnt     <= '0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    sh_min <= dd_step(sh_min);
                    sh_sec <= dd_step(sh_sec);
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd5) state <= LOAD;
                end
                LOAD: begin
                    dig[3] <= sh_min[13:10];
                    dig[2] <= sh_min[9:6];
                    dig[1] <= sh_sec[13:10];
                    dig[0] <= sh_sec[9:6];
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan timer: advance the active digit every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blink timer: free-running, flips the blink phase every BLINK_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Registered display outputs: blank beats blink, blink-off darkens anodes
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else if (blink && !phase) begin
            an  <= '1;
            seg <= seg_code(dig[idx]);
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_code(dig[idx]);
            dp  <= (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display: the stimulus process predicts every
// output cycle from arithmetic on time and input history; a monitor compares.
module tb_time_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] minutes = '0;
    logic [5:0] seconds = '0;
    logic       blank = 1'b0;
    logic       blink = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    time_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .minutes(minutes),
        .seconds(seconds),
        .blank  (blank),
        .blink  (blink),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       seg_chk;
        int         step;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    // Reference model state (values as seen just before each clock edge)
    int         m_cyc;
    int         m_busy;
    int         cap_m;
    int         cap_s;
    int         disp[4];
    logic [6:0] code_tab[10];

    initial begin
        code_tab[0] = 7'b1000000; code_tab[1] = 7'b1111001;
        code_tab[2] = 7'b0100100; code_tab[3] = 7'b0110000;
        code_tab[4] = 7'b0011001; code_tab[5] = 7'b0010010;
        code_tab[6] = 7'b0000010; code_tab[7] = 7'b1111000;
        code_tab[8] = 7'b0000000; code_tab[9] = 7'b0010000;
        m_cyc = 0; m_busy = 0; cap_m = 0; cap_s = 0;
        for (int i = 0; i < 4; i++) disp[i] = 0;
    end

    // Predict the outputs produced by the next clock edge, then advance the model
    task automatic model_edge(input logic r, input int mi, input int se,
                              input logic bl, input logic bk);
        exp_t e;
        int   di;
        logic ph_on;
        e.step = step_no;
        e.seg_chk = 1'b1;
        if (r) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            m_cyc = 0; m_busy = 0; cap_m = 0; cap_s = 0;
            for (int i = 0; i < 4; i++) disp[i] = 0;
        end else begin
            di    = (m_cyc / SCAN_DIV) % 4;
            ph_on = ((m_cyc / BLINK_DIV) % 2) == 0;
            e.seg = (disp[di] <= 9) ? code_tab[disp[di]] : 7'h7F;
            if (bl) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            end else if (bk && !ph_on) begin
                e.an = 4'hF; e.dp = 1'b1; e.seg_chk = 1'b0;
            end else begin
                e.an = 4'hF & ~(4'b0001 << di);
                e.dp = (di == 2) ? 1'b0 : 1'b1;
            end
            // Conversion timing: capture edge, six busy edges, load on the 8th
            if (m_busy == 0) begin
                if (mi != cap_m || se != cap_s) begin
                    cap_m  = mi;
                    cap_s  = se;
                    m_busy = 7;
                end
            end else if (m_busy == 1) begin
                disp[3] = cap_m / 10; disp[2] = cap_m % 10;
                disp[1] = cap_s / 10; disp[0] = cap_s % 10;
                m_busy  = 0;
            end else begin
                m_busy = m_busy - 1;
            end
            m_cyc = m_cyc + 1;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input int mi, input int se,
                         input logic bl, input logic bk, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst     = r;
            minutes = 6'(mi);
            seconds = 6'(se);
            blank   = bl;
            blink   = bk;
            step_no = step_no + 1;
            model_edge(r, mi, se, bl, bk);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                tests = tests + 1;
                if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
                    fails = fails + 1;
                    $display("FAIL out step %0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b (seg checked %0b)",
                             e.step, an, seg, dp, e.an, e.seg, e.dp, e.seg_chk);
                end
            end
        end
    end

    initial begin
        int mi, se;
        logic bl, bk;
        // Reset held two cycles, then idle at 0:00
        drive(1'b1, 0, 0, 1'b0, 1'b0, 2);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 6);
        // 12:34 through a few full scan rotations
        drive(1'b0, 12, 34, 1'b0, 1'b0, 40);
        // 59:59 then back to 0:00
        drive(1'b0, 59, 59, 1'b0, 1'b0, 24);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 24);
        // Seconds change 7 -> 8 while the first conversion is running
        drive(1'b0, 0, 7, 1'b0, 1'b0, 3);
        drive(1'b0, 0, 8, 1'b0, 1'b0, 24);
        // Out-of-range values convert without saturation
        drive(1'b0, 63, 60, 1'b0, 1'b0, 20);
        // Blink, then blank overriding blink
        drive(1'b0, 12, 34, 1'b0, 1'b1, 40);
        drive(1'b0, 12, 34, 1'b1, 1'b1, 5);
        drive(1'b0, 12, 34, 1'b1, 1'b0, 3);
        drive(1'b0, 12, 34, 1'b0, 1'b0, 6);
        // Reset during a conversion, with blank/blink asserted too
        drive(1'b0, 45, 17, 1'b0, 1'b0, 3);
        drive(1'b1, 45, 17, 1'b1, 1'b1, 1);
        drive(1'b0, 45, 17, 1'b0, 1'b0, 24);
        // Randomized traffic
        mi = 0; se = 0; bl = 1'b0; bk = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            if ($urandom_range(11) == 0) begin
                mi = int'($urandom_range(63));
                se = int'($urandom_range(63));
            end
            if ($urandom_range(29) == 0) bk = ~bk;
            if ($urandom_range(39) == 0) bl = ~bl;
            drive(($urandom_range(299) == 0) ? 1'b1 : 1'b0, mi, se, bl, bk, 1);
        end
        // Drain: the monitor consumes the last entries within two edges
        repeat (3) @(posedge clk);
        #2;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 Parameter SCAN_DIV, default 32500, clk cycles each digit is driven (~1 ms at 32.5 MHz).
REQ-002 Parameter BLINK_DIV, default 16250000, clk cycles per blink half-period (~0.5 s).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 minutes  input  6  elapsed minutes from stopwatch, binary, nominal 0-59.
REQ-006 seconds  input  6  elapsed seconds from stopwatch, binary, nominal 0-59.
REQ-007 blank  input  1  high: all digits dark.
REQ-008 blink  input  1  high: display flashes at BLINK_DIV rate (stopwatch paused).
REQ-009 an  output  4  digit anodes, active-low; an[3] minutes tens ... an[0] seconds ones.
REQ-010 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Conversion FSM states: IDLE, CONVERT, LOAD.
REQ-013 IDLE: when {minutes,seconds} differs from last captured pair, capture both into shadow registers and go to CONVERT; otherwise stay.
REQ-014 CONVERT: double-dabble binary-to-BCD on both captured values in parallel, exactly 6 shift cycles (add-3 on nibbles >=5 before each shift), then LOAD.
REQ-015 LOAD: one cycle; copy four BCD digits into display digit registers; return to IDLE.
REQ-016 Latency: digit registers update 8 clk cycles after input change is sampled in IDLE (1 capture + 6 convert + 1 load).
REQ-017 Input changes during CONVERT/LOAD are ignored; re-compared on return to IDLE, triggering a new conversion if different.
REQ-018 Values 60-63 are converted without saturation (e.g. 63 -> digits 6,3).
REQ-019 Scan counter counts 0..SCAN_DIV-1; on wrap, digit index increments 0->1->2->3->0.
REQ-020 Digit index i drives an with bit i low, others high; seg shows digit register i.
REQ-021 Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code=1111111.
REQ-022 dp low only while index 2 (minutes ones) is active, forming MM.SS; else high.
REQ-023 Blink counter counts 0..BLINK_DIV-1, toggling blink phase on wrap; runs continuously regardless of blink input.
REQ-024 blink high and phase=off: an=1111, dp=1; scan and conversion continue unaffected.
REQ-025 blank high overrides blink: an=1111, seg=1111111, dp=1.
REQ-026 an, seg, dp are registered; blank/blink/index changes reach outputs 1 cycle later.

Reset
REQ-027 rst forces: FSM IDLE, captured pair and digit registers 0, scan counter 0, index 0, blink counter 0, phase on, an=1111, seg=1111111, dp=1.
REQ-028 rst during CONVERT aborts conversion; digit registers return to 0; first cycle after reset compares inputs against 0:00 and converts if different.
REQ-029 rst dominates blank, blink and all inputs in the same cycle.

Verification
REQ-030 Reset asserted 2 cycles -> an=1111, seg=1111111, dp=1; next cycle an=1110, seg=1000000 (digit 0).
REQ-031 SCAN_DIV=4, minutes=12, seconds=34 -> after 8 cycles digits 1,2,3,4; anodes cycle 1110,1101,1011,0111, 4 cycles each, seg 0011001,0110000,0100100,1111001; dp=0 only with an=1011.
REQ-032 minutes=59, seconds=59 then 0:00 -> 5,9,5,9 then 0,0,0,0, each 8 cycles after change.
REQ-033 seconds 7->8 at CONVERT cycle 3 -> display shows 7, then 8 after second conversion completes.
REQ-034 BLINK_DIV=8, blink=1 -> an=1111 for 8 cycles, scanning for 8, repeating; blank=1 -> an=1111, seg=1111111 one cycle later.
